// File: rtl/creek_pkg.sv
// Shared constants and state encoding for the creek vector core fetch path.
package creek_pkg;

  localparam int CREEK_ADDR_WIDTH  = 10;
  localparam int CREEK_INSTR_WIDTH = 16;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    RUN,
    PAUSED,
    DRAIN
  } fetch_state_t;

  // RUN and PAUSED are the states in which a program is live.
  function automatic logic is_active(input fetch_state_t s);
    return (s == RUN) || (s == PAUSED);
  endfunction

endpackage

// File: rtl/creek_fetch_fifo.sv
// Two-entry skid FIFO holding packed {pc, instr} words between fetch and decode.
module creek_fetch_fifo #(
  parameter int WIDTH = 26
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);
  assign head  = mem[rd_ptr];

  // A push into a full FIFO is allowed only when the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (do_push && !do_pop) begin
        count <= count + 2'd1;
      end else if (!do_push && do_pop) begin
        count <= count - 2'd1;
      end
    end
  end

endmodule

// File: rtl/creek_instr_fetch.sv
// Instruction fetch stage: memory read port, skid FIFO to decode, host control handshake.
// Optional stall counter built when CREEK_FETCH_PERFCNT_EN is defined.
module creek_instr_fetch
  import creek_pkg::*;
#(
  parameter int ADDR_WIDTH  = CREEK_ADDR_WIDTH,
  parameter int INSTR_WIDTH = CREEK_INSTR_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   local_init_done,
  input  logic                   pause_n,
  input  logic                   resume,
  output logic                   waiting,
  output logic [ADDR_WIDTH-1:0]  instr_address,
  input  logic [INSTR_WIDTH-1:0] instr_data,
  input  logic                   halt,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0]  out_pc,
  output logic [31:0]            stall_cycles
);

  localparam int                    ENTRY_WIDTH = ADDR_WIDTH + INSTR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PC_ONE      = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  fetch_state_t           state;
  fetch_state_t           next_state;
  logic [ADDR_WIDTH-1:0]  pc;
  logic [ADDR_WIDTH-1:0]  pc_next;
  logic [ADDR_WIDTH-1:0]  issue_addr;
  logic                   issue;
  logic                   inflight;
  logic                   active;
  logic                   start;
  logic                   halt_take;
  logic                   redirect_take;
  logic                   can_issue;
  logic                   room;
  logic                   pop;
  logic                   flush;
  logic                   push;
  logic [ENTRY_WIDTH-1:0] fifo_head;
  logic [1:0]             fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;

  assign active        = is_active(state);
  assign start         = (state == IDLE) && resume && pause_n;
  assign halt_take     = active && halt;
  assign redirect_take = active && redirect_valid && !halt;
  assign can_issue     = (state == RUN) && pause_n;
  assign pop           = out_valid && out_ready;
  assign flush         = halt_take || redirect_take;
  assign push          = inflight && !flush;

  // Issue only if the word would still fit once everything already in flight has landed.
  assign room = fifo_full ? (pop && !inflight) : (fifo_empty || pop || !inflight);

  always_comb begin
    next_state = state;
    case (state)
      INIT:    if (local_init_done) next_state = IDLE;
      IDLE:    if (start) next_state = RUN;
      RUN: begin
        if (halt)          next_state = DRAIN;
        else if (!pause_n) next_state = PAUSED;
      end
      PAUSED: begin
        if (halt)         next_state = DRAIN;
        else if (pause_n) next_state = RUN;
      end
      DRAIN:   next_state = IDLE;
      default: next_state = INIT;
    endcase
  end

  // A redirect while paused only retargets the PC; the read goes out once fetch resumes.
  always_comb begin
    issue      = 1'b0;
    issue_addr = pc;
    pc_next    = pc;
    if (start) begin
      issue      = 1'b1;
      issue_addr = '0;
    end else if (redirect_take) begin
      issue      = can_issue;
      issue_addr = redirect_pc;
      pc_next    = redirect_pc;
    end else if (!halt_take && can_issue && room) begin
      issue = 1'b1;
    end
    if (issue) begin
      pc_next = issue_addr + PC_ONE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= INIT;
      pc            <= '0;
      instr_address <= '0;
      inflight      <= 1'b0;
      waiting       <= 1'b0;
    end else begin
      state    <= next_state;
      pc       <= pc_next;
      inflight <= issue;
      waiting  <= (next_state == IDLE);
      if (issue) begin
        instr_address <= issue_addr;
      end
    end
  end

  creek_fetch_fifo #(
    .WIDTH(ENTRY_WIDTH)
  ) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .flush    (flush),
    .push     (push),
    .push_data({instr_address, instr_data}),
    .pop      (pop),
    .head     (fifo_head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_pc    = fifo_head[ENTRY_WIDTH-1:INSTR_WIDTH];
  assign out_instr = fifo_head[INSTR_WIDTH-1:0];

`ifdef CREEK_FETCH_PERFCNT_EN
  logic [31:0] stall_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
    end else if (start) begin
      stall_count <= '0;
    end else if (active && out_valid && !out_ready && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end

  assign stall_cycles = stall_count;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_creek_instr_fetch.sv
// Randomized self-checking bench for creek_instr_fetch against a queue-based fetch model.
// Honours CREEK_FETCH_PERFCNT_EN for the expected stall counter.
module tb_creek_instr_fetch;

  localparam int M_INIT   = 0;
  localparam int M_IDLE   = 1;
  localparam int M_RUN    = 2;
  localparam int M_PAUSED = 3;
  localparam int M_DRAIN  = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        local_init_done;
  logic        pause_n;
  logic        resume;
  logic        waiting;
  logic [9:0]  instr_address;
  logic [15:0] instr_data;
  logic        halt;
  logic        redirect_valid;
  logic [9:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [9:0]  out_pc;
  logic [31:0] stall_cycles;

  logic [15:0] mem [1024];

  int          vectors     = 0;
  int          miscompares = 0;

  int          mState;
  int          mPc;
  int          mAddr;
  bit          mInfl;
  int          mQ[$];
  int unsigned mStall;

  always #5 clock = ~clock;

  assign instr_data = mem[instr_address];

  creek_instr_fetch dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .local_init_done(local_init_done),
    .pause_n        (pause_n),
    .resume         (resume),
    .waiting        (waiting),
    .instr_address  (instr_address),
    .instr_data     (instr_data),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .stall_cycles   (stall_cycles)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mState = M_INIT;
    mPc    = 0;
    mAddr  = 0;
    mInfl  = 1'b0;
    mQ.delete();
    mStall = 0;
  endtask

  task automatic modelIssue();
    mAddr = mPc;
    mPc   = (mPc + 1) % 1024;
    mInfl = 1'b1;
  endtask

  // One clock edge of the fetch behaviour, evaluated from the inputs held across that edge.
  task automatic modelStep();
    bit pop;
    bit landing;
    bit canIssue;
    int occ;
    int landed;
    pop     = (mQ.size() > 0) && out_ready;
    occ     = mQ.size() + int'(mInfl) - int'(pop);
    landing = mInfl;
    landed  = mAddr;
`ifdef CREEK_FETCH_PERFCNT_EN
    if ((mState == M_RUN || mState == M_PAUSED) && mQ.size() > 0 && !out_ready && mStall != 32'hFFFF_FFFF)
      mStall++;
`endif
    case (mState)
      M_INIT: if (local_init_done) mState = M_IDLE;
      M_IDLE: begin
        if (resume && pause_n) begin
          mState = M_RUN;
          mStall = 0;
          mPc    = 0;
          modelIssue();
        end
      end
      M_RUN, M_PAUSED: begin
        if (halt) begin
          mQ.delete();
          mInfl  = 1'b0;
          mState = M_DRAIN;
        end else begin
          canIssue = (mState == M_RUN) && pause_n;
          if (pop) void'(mQ.pop_front());
          mInfl = 1'b0;
          if (redirect_valid) begin
            mQ.delete();
            mPc = int'(redirect_pc);
            if (canIssue) modelIssue();
          end else begin
            if (landing) mQ.push_back(landed);
            if (canIssue && occ < 2) modelIssue();
          end
          if (mState == M_RUN && !pause_n) mState = M_PAUSED;
          else if (mState == M_PAUSED && pause_n) mState = M_RUN;
        end
      end
      M_DRAIN: mState = M_IDLE;
      default: mState = M_INIT;
    endcase
  endtask

  task automatic checkAll();
    checkOutput("waiting", 32'(waiting), 32'(mState == M_IDLE));
    checkOutput("instr_address", 32'(instr_address), 32'(mAddr));
    checkOutput("out_valid", 32'(out_valid), 32'(mQ.size() > 0));
    if (mQ.size() > 0) begin
      checkOutput("out_pc", 32'(out_pc), 32'(mQ[0]));
      checkOutput("out_instr", 32'(out_instr), 32'(mem[mQ[0]]));
    end
    checkOutput("stall_cycles", stall_cycles, mStall);
  endtask

  task automatic checkResetValues();
    checkOutput("rst_waiting", 32'(waiting), 32'd0);
    checkOutput("rst_instr_address", 32'(instr_address), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_pc", 32'(out_pc), 32'd0);
    checkOutput("rst_out_instr", 32'(out_instr), 32'd0);
    checkOutput("rst_stall_cycles", stall_cycles, 32'd0);
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model at the rising edge, check next fall.
  task automatic applyStimulus(input bit ldone, input bit pn, input bit res, input bit hlt,
                               input bit rv, input logic [9:0] rpc, input bit rdy);
    local_init_done = ldone;
    pause_n         = pn;
    resume          = res;
    halt            = hlt;
    redirect_valid  = rv;
    redirect_pc     = rpc;
    out_ready       = rdy;
    @(posedge clock);
    if (!reset_n) modelReset();
    else modelStep();
    @(negedge clock);
    checkAll();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    reset_n         = 1'b0;
    local_init_done = 1'b0;
    pause_n         = 1'b1;
    resume          = 1'b0;
    halt            = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    out_ready       = 1'b0;
    modelReset();
    @(negedge clock);
    checkResetValues();
    repeat (2) applyStimulus(0, 1, 0, 0, 0, 10'd0, 0);
    reset_n = 1'b1;

    // Calibration completes at cycle 10; resume at cycle 15.
    for (int c = 0; c < 15; c++) applyStimulus(c >= 10, 1, 0, 0, 0, 10'd0, 1);
    applyStimulus(1, 1, 1, 0, 0, 10'd0, 1);
    repeat (12) applyStimulus(1, 1, 0, 0, 0, 10'd0, 1);

    repeat (5) applyStimulus(1, 1, 0, 0, 0, 10'd0, 0);

    // Redirect near the top of memory while the FIFO is full, then watch the wrap.
    applyStimulus(1, 1, 0, 0, 1, 10'h3FE, 0);
    repeat (8) applyStimulus(1, 1, 0, 0, 0, 10'd0, 1);

    repeat (8) applyStimulus(1, 0, 0, 0, 0, 10'd0, 1);
    repeat (6) applyStimulus(1, 1, 0, 0, 0, 10'd0, 1);

    for (int c = 0; c < 400; c++) begin
      bit rv;
      logic [9:0] rpc;
      rv  = ($urandom_range(0, 14) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 10'(1020 + $urandom_range(0, 3)) : 10'($urandom_range(0, 1023));
      applyStimulus(1, $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 39) == 0, rv, rpc, $urandom_range(0, 9) < 7);
    end

    // Force a known IDLE, run, then halt and redirect together.
    applyStimulus(1, 1, 0, 1, 0, 10'd0, 1);
    repeat (2) applyStimulus(1, 1, 0, 0, 0, 10'd0, 1);
    applyStimulus(1, 1, 1, 0, 0, 10'd0, 1);
    repeat (4) applyStimulus(1, 1, 0, 0, 0, 10'd0, 1);
    applyStimulus(1, 1, 0, 1, 1, 10'h155, 1);
    repeat (6) applyStimulus(1, 1, 0, 0, 0, 10'd0, 1);

    // Fill the FIFO during RUN, then pulse reset between clock edges.
    applyStimulus(1, 1, 1, 0, 0, 10'd0, 0);
    repeat (4) applyStimulus(1, 1, 0, 0, 0, 10'd0, 0);
    #2 reset_n = 1'b0;
    #1 checkResetValues();
    modelReset();
    @(negedge clock);
    checkAll();
    reset_n = 1'b1;
    repeat (2) applyStimulus(0, 1, 0, 0, 0, 10'd0, 1);
    repeat (3) applyStimulus(1, 1, 0, 0, 0, 10'd0, 1);
    applyStimulus(1, 1, 1, 0, 0, 10'd0, 1);
    repeat (6) applyStimulus(1, 1, 0, 0, 0, 10'd0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/creek_instr_fetch.md
# creek_instr_fetch

Instruction fetch stage for the creek vector core. It drives the read port of the 1024×16 instruction memory and absorbs that memory's one-cycle read latency. It buffers fetched words in a 2-entry skid FIFO and hands them downstream to decode over a valid/ready handshake. It also owns the host pause/resume/waiting control handshake and holds off fetching until the DDR3 controller reports `local_init_done`.

## Interface
- `ADDR_WIDTH`, 10, instruction-memory address width (PC width)
- `INSTR_WIDTH`, 16, instruction word width
- `clock`  in  1  single clock for the block
- `reset_n`  in  1  reset; asynchronous, active-low
- `local_init_done`  in  1  DDR3 calibration complete; level
- `pause_n`  in  1  host pause; low = freeze fetch
- `resume`  in  1  host start pulse, one cycle
- `waiting`  out  1  high when idle and ready for `resume`
- `instr_address`  out  ADDR_WIDTH  instruction-memory read address, registered
- `instr_data`  in  INSTR_WIDTH  instruction-memory read data; valid one cycle after the address
- `halt`  in  1  pulse from decode; ends the program
- `redirect_valid`  in  1  jump/branch-taken pulse
- `redirect_pc`  in  ADDR_WIDTH  jump target
- `out_valid`  out  1  fetched word available
- `out_ready`  in  1  decode accepts the word
- `out_instr`  out  INSTR_WIDTH  fetched word
- `out_pc`  out  ADDR_WIDTH  address of `out_instr`
- `stall_cycles`  out  32  count of cycles with `out_valid=1` and `out_ready=0`

## Operation
- States:
  - INIT: before `local_init_done`.
  - IDLE: `waiting=1`.
  - RUN
  - PAUSED
  - DRAIN: flush before returning to IDLE.
- Transitions:
  - INIT→IDLE when `local_init_done=1`.
  - IDLE→RUN on `resume=1` with `pause_n=1`. PC is set to 0.
  - RUN→PAUSED when `pause_n=0`. No new reads are issued; the in-flight read still lands in the FIFO; the FIFO still drains to decode.
  - PAUSED→RUN when `pause_n=1`. Fetch continues from the held PC.
  - RUN or PAUSED→DRAIN on `halt`. The FIFO and the in-flight read are discarded. DRAIN→IDLE after one cycle.
- Fetch issue in RUN:
  - A read is issued when (FIFO count + in-flight − pop this cycle) < 2.
  - On issue, `instr_address` ← PC and PC ← PC+1, modulo 2^ADDR_WIDTH (1023 wraps to 0).
- Redirect:
  - The FIFO is flushed and any in-flight read is squashed (its data is not written).
  - The next issued address is `redirect_pc`.
  - Redirect is ignored outside RUN/PAUSED.
- Simultaneous events:
  - `halt` beats `redirect_valid`.
  - `resume` while not in IDLE is ignored.
  - Redirect and pop in the same cycle: the popped word is consumed and everything else is flushed.
- `out_pc`/`out_instr` are held stable while `out_valid=1` and `out_ready=0`.

## Timing
- Reset values:
  - state INIT, PC 0
  - `instr_address=0`
  - `waiting=0`
  - `out_valid=0`
  - `out_instr=0`, `out_pc=0`
  - `stall_cycles=0`
- `waiting` is registered. It rises the cycle after entering IDLE and falls the cycle after `resume` is sampled.
- Latency from `resume` to first valid: `resume` is sampled at edge E0 (`instr_address=0` after E0). Data is captured at E1. `out_valid=1` after E1.
- Throughput: one word per cycle when `out_ready` is held at 1.
- Redirect sampled at edge E: `instr_address=redirect_pc` after E, `out_valid=1` after E+1.
- Reset asserted mid-operation returns all state to reset values immediately (asynchronously).

## Configuration
- `CREEK_FETCH_PERFCNT_EN` defined: `stall_cycles` increments in every RUN/PAUSED cycle with `out_valid=1 && out_ready=0`. It saturates at 0xFFFF_FFFF and clears on `resume`.
- Not defined: `stall_cycles` is tied to 0 and no counter logic is built.

## Structure
- Shared package `creek_pkg`:
  - `CREEK_ADDR_WIDTH`, `CREEK_INSTR_WIDTH` constants
  - `fetch_state_t` enum (INIT, IDLE, RUN, PAUSED, DRAIN)
- One sub-module, `creek_fetch_fifo`: 2-entry FIFO of {pc, instr} with a synchronous flush input, and count, full and empty outputs.

## Test plan
- Reset with `local_init_done=0`, then raise it at cycle 10 → `waiting=1` at cycle 11; `resume` at cycle 15 → `instr_address` 0,1,2… and `out_pc` 0,1,2… each cycle, with the first `out_valid` two edges after `resume`.
- Hold `out_ready=0` for 5 cycles mid-stream → no word lost or duplicated, `out_pc` held, FIFO stops at 2 entries, and `stall_cycles=5` with the macro (0 without it).
- `redirect_valid` with `redirect_pc=0x3FE` while the FIFO is full → old words dropped; sequence continues 0x3FE, 0x3FF, 0x000 (wrap).
- `pause_n=0` for 8 cycles → no address change, FIFO drains; `pause_n=1` → fetch resumes at the held PC.
- `halt` and `redirect_valid` in the same cycle → DRAIN then IDLE, `waiting=1`, and no further `out_valid`.
- `reset_n` pulsed low during RUN with a full FIFO → all outputs at reset values asynchronously; state INIT.
